// File: rtl/pkt_af_fifo.sv
// Show-ahead packet FIFO with almost-full hysteresis for a sender that has no ready input.
// Words that cannot be stored are dropped and counted; a packet that overflows is dropped through its eop.
module pkt_af_fifo #(
    parameter int DEPTH    = 64,
    parameter int AF_SET   = 48,
    parameter int AF_CLEAR = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [511:0]             in_data,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [5:0]               in_empty,
    input  logic                     in_valid,
    output logic                     in_almost_full,
    output logic [511:0]             out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [5:0]               out_empty,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [31:0]              drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int WORD_W = 512 + 1 + 1 + 6;

    localparam logic [PW-1:0] DEPTH_C    = PW'(DEPTH);
    localparam logic [PW-1:0] AF_SET_C   = PW'(AF_SET);
    localparam logic [PW-1:0] AF_CLEAR_C = PW'(AF_CLEAR);

    typedef enum logic {PASS, DROP} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, occ, occ_nxt;
    state_t            state, state_nxt;
    logic              pop, push, drop, accept, eval_pass, full;

    assign {out_data, out_sop, out_eop, out_empty} = mem[rd_ptr[AW-1:0]];
    assign out_valid = (occ != '0);
    assign occupancy = occ;
    assign full      = (occ == DEPTH_C);
    assign pop       = out_valid & out_ready;

    // An sop without eop while dropping means the previous eop was lost: judge it as PASS.
    always_comb begin
        eval_pass = (state == PASS) || (in_sop && !in_eop);
        accept    = eval_pass && (!full || pop);
        push      = in_valid && accept;
        drop      = in_valid && !accept;
        state_nxt = state;
        if (in_valid) begin
            if (eval_pass)
                state_nxt = (!accept && !in_eop) ? DROP : PASS;
            else if (in_eop)
                state_nxt = PASS;
        end
        case ({push, pop})
            2'b10:   occ_nxt = occ + PW'(1);
            2'b01:   occ_nxt = occ - PW'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            state          <= PASS;
            in_almost_full <= 1'b0;
            overflow       <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            occ   <= occ_nxt;
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (occ_nxt >= AF_SET_C)
                in_almost_full <= 1'b1;
            else if (occ_nxt <= AF_CLEAR_C)
                in_almost_full <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {in_data, in_sop, in_eop, in_empty};
    end

endmodule

// File: tb/tb_pkt_af_fifo.sv
// Directed bench for pkt_af_fifo (DEPTH=16, AF_SET=12, AF_CLEAR=8) with a queue scoreboard
// filled by the driver and drained by a monitor thread whenever the head word is consumed.
module tb_pkt_af_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_data;
    logic         in_sop, in_eop, in_valid;
    logic [5:0]   in_empty;
    logic         in_almost_full;
    logic [511:0] out_data;
    logic         out_sop, out_eop, out_valid;
    logic [5:0]   out_empty;
    logic         out_ready;
    logic [4:0]   occupancy;
    logic         overflow;
    logic [31:0]  drop_cnt;

    int           tests = 0;
    int           fails = 0;
    logic [519:0] sb_q[$];
    logic [4:0]   max_occ;

    pkt_af_fifo #(.DEPTH(16), .AF_SET(12), .AF_CLEAR(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .in_valid(in_valid), .in_almost_full(in_almost_full),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive a word (if v), record it as expected when it should be stored.
    task automatic cyc(input logic v, input logic s, input logic e, input logic [31:0] id,
                       input logic rdy, input logic exp_acc);
        logic [511:0] d;
        d         = {16{id}};
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        in_data   = d;
        in_empty  = id[5:0];
        out_ready = rdy;
        if (v && exp_acc)
            sb_q.push_back({d, s, e, id[5:0]});
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [519:0] exp_w;
        logic [519:0] act_w;
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; in_empty = '0; out_ready = 1'b0; max_occ = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && occupancy > max_occ)
                    max_occ = occupancy;
                if (!rst && out_valid && out_ready) begin
                    act_w = {out_data, out_sop, out_eop, out_empty};
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pop", act_w[31:0], 32'hFFFF_FFFF);
                    end else begin
                        exp_w = sb_q.pop_front();
                        tests++;
                        if (act_w !== exp_w) begin
                            fails++;
                            $display("FAIL head_word: got id %0h sop%0b eop%0b emp%0h expected id %0h sop%0b eop%0b emp%0h",
                                     act_w[39:8], act_w[7], act_w[6], act_w[5:0],
                                     exp_w[39:8], exp_w[7], exp_w[6], exp_w[5:0]);
                        end
                    end
                end
            end
        join_none

        // Reset with in_valid asserted: must not count as a drop.
        in_valid = 1'b1; in_data = {16{32'hDEAD}};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_af", 32'(in_almost_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", drop_cnt, 32'd0);

        // Pass-through of a 4-word packet.
        max_occ = '0;
        cyc(1'b1, 1'b1, 1'b0, 32'd1, 1'b1, 1'b1);
        chk("pt_latency_valid", 32'(out_valid), 32'd1);
        chk("pt_latency_data", out_data[31:0], 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd2, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'd4, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("pt_occ_drained", 32'(occupancy), 32'd0);
        chk("pt_max_occ", 32'(max_occ), 32'd1);
        chk("pt_drop_cnt", drop_cnt, 32'd0);

        // Almost-full hysteresis.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, i == 0, i == 11, 32'd10 + 32'(i), 1'b0, 1'b1);
            if (i == 10) chk("af_after_11", 32'(in_almost_full), 32'd0);
        end
        chk("af_after_12", 32'(in_almost_full), 32'd1);
        chk("af_occ_12", 32'(occupancy), 32'd12);
        idle(3, 1'b1);
        chk("af_occ_9", 32'(occupancy), 32'd9);
        chk("af_hold_9", 32'(in_almost_full), 32'd1);
        idle(1, 1'b1);
        chk("af_occ_8", 32'(occupancy), 32'd8);
        chk("af_clear_8", 32'(in_almost_full), 32'd0);

        // Fill to 16, then push and pop together while full.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b0, 1'b0, 32'd30 + 32'(i), 1'b0, 1'b1);
        chk("full_occ", 32'(occupancy), 32'd16);
        cyc(1'b1, 1'b0, 1'b0, 32'd38, 1'b1, 1'b1);
        chk("full_pushpop_occ", 32'(occupancy), 32'd16);
        chk("full_pushpop_drop", drop_cnt, 32'd0);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);

        // Mid-packet overflow: words 3..5 of a 5-word packet arrive at full.
        idle(2, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'd40, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd41, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'd43, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'd44, 1'b0, 1'b0);
        chk("ovf_drop_cnt", drop_cnt, 32'd3);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_occ", 32'(occupancy), 32'd16);
        idle(1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'd45, 1'b0, 1'b1);
        chk("ovf_next_pkt_occ", 32'(occupancy), 32'd16);
        chk("ovf_next_pkt_drop", drop_cnt, 32'd3);

        // Enter DROP, stay there with space free, then recover on an sop-only word.
        cyc(1'b1, 1'b0, 1'b0, 32'd50, 1'b0, 1'b0);
        chk("drop_enter_cnt", drop_cnt, 32'd4);
        idle(1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd51, 1'b0, 1'b0);
        chk("drop_mid_cnt", drop_cnt, 32'd5);
        chk("drop_mid_occ", 32'(occupancy), 32'd15);
        cyc(1'b1, 1'b1, 1'b0, 32'd52, 1'b0, 1'b1);
        chk("lost_eop_occ", 32'(occupancy), 32'd16);
        chk("lost_eop_cnt", drop_cnt, 32'd5);
        idle(1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd53, 1'b0, 1'b1);
        chk("lost_eop_pass_occ", 32'(occupancy), 32'd16);
        chk("lost_eop_pass_cnt", drop_cnt, 32'd5);

        // Reset mid-operation at occ=10 with almost-full asserted.
        idle(6, 1'b1);
        chk("pre_rst_occ", 32'(occupancy), 32'd10);
        chk("pre_rst_af", 32'(in_almost_full), 32'd1);
        rst = 1'b1; in_valid = 1'b1; in_data = {16{32'd60}};
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_af", 32'(in_almost_full), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_drop_cnt", drop_cnt, 32'd0);

        // First word after reset is judged under PASS rules even without sop.
        cyc(1'b1, 1'b0, 1'b0, 32'd61, 1'b0, 1'b1);
        chk("post_rst_occ", 32'(occupancy), 32'd1);
        idle(2, 1'b1);
        chk("final_occ", 32'(occupancy), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
